// File: rtl/wb_arb_defs.sv
// Shared Wishbone arbiter definitions: FSM encodings, bus widths and the per-master request payload.
package wb_arb_defs;

   localparam int unsigned WB_AW = 32;
   localparam int unsigned WB_DW = 32;
   localparam int unsigned WB_SW = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN   = 2'd1,
      ABORT = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [WB_AW-1:0] adr;
      logic [WB_DW-1:0] dat;
      logic [WB_SW-1:0] sel;
      logic             we;
   } wb_req_t;

   // Index of the set bit in a one-hot vector of up to eight masters.
   function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after ptr.
module rr_pick #(
   parameter int unsigned NM = 3
) (
   input  logic [NM-1:0]         req,
   input  logic [$clog2(NM)-1:0] ptr,
   output logic [NM-1:0]         gnt,
   output logic                  any
);

   localparam int unsigned PW = $clog2(NM);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NM; i++) begin
         idx = PW'((32'(ptr) + i) % NM);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave port, ownership held for the
// whole cyc, with a watchdog that aborts unacknowledged cycles with an err to the owner.
module wb_rr_arbiter
   import wb_arb_defs::*;
#(
   parameter int unsigned NM      = 3,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CW      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NM*WB_AW-1:0]   m_adr_i,
   input  logic [NM*WB_DW-1:0]   m_dat_i,
   input  logic [NM*WB_SW-1:0]   m_sel_i,
   input  logic [NM-1:0]         m_we_i,
   input  logic [NM-1:0]         m_cyc_i,
   input  logic [NM-1:0]         m_stb_i,
   output logic [WB_DW-1:0]      m_dat_o,
   output logic [NM-1:0]         m_ack_o,
   output logic [NM-1:0]         m_err_o,
   output logic [WB_AW-1:0]      s_adr_o,
   output logic [WB_DW-1:0]      s_dat_o,
   output logic [WB_SW-1:0]      s_sel_o,
   output logic                  s_we_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   input  logic                  s_ack_i,
   input  logic [WB_DW-1:0]      s_dat_i,
   output logic [NM-1:0]         grant_o,
   output logic                  timeout_o
);

   localparam int unsigned PW = $clog2(NM);

   arb_state_e    state_q, state_d;
   logic [NM-1:0] grant_q, grant_d;
   logic [PW-1:0] gidx_q, gidx_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] wd_q, wd_d;

   logic [NM-1:0] pick_gnt;
   logic          pick_any;
   logic          own_cyc;
   logic          own_stb;
   logic [PW-1:0] nxt_ptr;
   wb_req_t       m_req [NM];
   wb_req_t       own_req;

   rr_pick #(.NM(NM)) u_pick (
      .req (m_cyc_i),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .any (pick_any)
   );

   for (genvar k = 0; k < NM; k++) begin : g_req
      assign m_req[k] = {m_adr_i[k*WB_AW +: WB_AW], m_dat_i[k*WB_DW +: WB_DW],
                         m_sel_i[k*WB_SW +: WB_SW], m_we_i[k]};
   end

   assign own_cyc = |(m_cyc_i & grant_q);
   assign own_stb = |(m_stb_i & grant_q);
   assign nxt_ptr = (gidx_q == PW'(NM - 1)) ? '0 : gidx_q + PW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
      end
   end

   // Release on cyc drop wins over a watchdog expiry in the same cycle.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      wd_d    = wd_q;
      unique case (state_q)
         IDLE: begin
            wd_d = '0;
            if (pick_any) begin
               state_d = OWN;
               grant_d = pick_gnt;
               gidx_d  = PW'(oh_to_idx(8'(pick_gnt)));
            end
         end
         OWN: begin
            if (!own_cyc) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = nxt_ptr;
               wd_d    = '0;
            end else if (own_stb && !s_ack_i) begin
               if (wd_q == CW'(TIMEOUT - 1)) begin
                  state_d = ABORT;
                  wd_d    = '0;
               end else begin
                  wd_d = wd_q + CW'(1);
               end
            end else begin
               wd_d = '0;
            end
         end
         ABORT: begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = nxt_ptr;
            wd_d    = '0;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            wd_d    = '0;
         end
      endcase
   end

   // AND-OR select of the owner's request; zero whenever no grant is held.
   always_comb begin
      own_req = '0;
      for (int unsigned k = 0; k < NM; k++) begin
         own_req = own_req | (m_req[k] & {$bits(wb_req_t){grant_q[k]}});
      end
   end

   assign s_adr_o   = own_req.adr;
   assign s_dat_o   = own_req.dat;
   assign s_sel_o   = own_req.sel;
   assign s_we_o    = own_req.we & (state_q == OWN);
   assign s_cyc_o   = own_cyc & (state_q == OWN);
   assign s_stb_o   = own_stb & (state_q == OWN);
   assign m_dat_o   = s_dat_i;
   assign m_ack_o   = (state_q == OWN) ? (grant_q & {NM{s_ack_i}}) : '0;
   assign m_err_o   = (state_q == ABORT) ? grant_q : '0;
   assign timeout_o = (state_q == ABORT);
   assign grant_o   = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: three masters, a slave model with programmable ack latency.
`timescale 1ns/1ps
module tb_wb_rr_arbiter;

   localparam int unsigned NM      = 3;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned CW      = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NM*32-1:0] m_adr, m_dat;
   logic [NM*4-1:0]  m_sel;
   logic [NM-1:0]    m_we, m_cyc, m_stb;
   logic [31:0]      m_dat_o;
   logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
   logic [31:0]      s_adr_o, s_dat_o;
   logic [3:0]       s_sel_o;
   logic             s_we_o, s_cyc_o, s_stb_o, timeout_o;
   logic             s_ack;
   logic [31:0]      s_dat;

   int checks   = 0;
   int failures = 0;
   int lat      = 1;
   bit no_ack   = 1'b0;
   int scnt;

   always #5 clk = ~clk;

   wb_rr_arbiter #(.NM(NM), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack), .s_dat_i(s_dat),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   // Slave model: single-cycle ack 'lat' cycles after strobe is first seen.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         scnt  <= 0;
         s_ack <= 1'b0;
      end else begin
         s_ack <= 1'b0;
         if (s_cyc_o && s_stb_o && !s_ack && !no_ack) begin
            if (scnt >= lat - 1) begin
               s_ack <= 1'b1;
               scnt  <= 0;
            end else begin
               scnt <= scnt + 1;
            end
         end else begin
            scnt <= 0;
         end
      end
   end

   task automatic drive(input int k, input logic cyc, input logic [31:0] adr);
      m_cyc[k]           = cyc;
      m_stb[k]           = cyc;
      m_adr[k*32 +: 32]  = adr;
      m_dat[k*32 +: 32]  = 32'hD0 + 32'(k);
      m_sel[k*4 +: 4]    = 4'hF;
      m_we[k]            = 1'b0;
   endtask

   task automatic apply_reset();
      m_cyc = '0; m_stb = '0; m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
      no_ack = 1'b0;
      lat    = 1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic wait_ack(input int k, input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (m_ack_o[k]) begin
            got = 1'b1;
            drive(k, 1'b0, 32'h0);
         end
      end
   endtask

   task automatic test_reset();
      s_dat = 32'h1234_5678;
      drive(0, 1'b0, 32'hFFFF_0000);
      #1 rst = 1'b0;
      #3;
      checks++;
      if ({m_ack_o, m_err_o, grant_o, timeout_o, s_cyc_o, s_stb_o, s_we_o} !== '0)
         begin failures++; $display("FAIL reset_ctrl got=%b exp=0", {m_ack_o, m_err_o, grant_o, timeout_o, s_cyc_o, s_stb_o, s_we_o}); end
      checks++;
      if (s_adr_o !== 32'h0 || s_dat_o !== 32'h0 || s_sel_o !== 4'h0)
         begin failures++; $display("FAIL reset_bus adr=%h dat=%h sel=%h exp=0", s_adr_o, s_dat_o, s_sel_o); end
      checks++;
      if (m_dat_o !== 32'h1234_5678)
         begin failures++; $display("FAIL reset_rdata got=%h exp=12345678", m_dat_o); end
      drive(0, 1'b1, 32'h0000_0040);
      @(negedge clk);
      checks++;
      if (s_cyc_o !== 1'b0 || grant_o !== 3'b000)
         begin failures++; $display("FAIL reset_hold cyc=%b grant=%b exp=0/000", s_cyc_o, grant_o); end
      drive(0, 1'b0, 32'h0);
   endtask

   task automatic test_single();
      logic [NM-1:0] exp_ack;
      apply_reset();
      lat   = 2;
      s_dat = 32'h0000_00A5;
      drive(1, 1'b1, 32'h2000_0004);
      #1;
      checks++;
      if (s_cyc_o !== 1'b0)
         begin failures++; $display("FAIL single_latency got=%b exp=0", s_cyc_o); end
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checks++;
         if (s_cyc_o !== 1'b1 || grant_o !== 3'b010 || s_adr_o !== 32'h2000_0004 || s_dat_o !== 32'hD1)
            begin failures++; $display("FAIL single_own cyc%0d cyc=%b grant=%b adr=%h dat=%h exp=1/010/20000004/d1", i, s_cyc_o, grant_o, s_adr_o, s_dat_o); end
         exp_ack = (i == 3) ? 3'b010 : 3'b000;
         checks++;
         if (m_ack_o !== exp_ack)
            begin failures++; $display("FAIL single_ack cyc%0d got=%b exp=%b", i, m_ack_o, exp_ack); end
      end
      checks++;
      if (m_dat_o !== 32'h0000_00A5)
         begin failures++; $display("FAIL single_rdata got=%h exp=a5", m_dat_o); end
      drive(1, 1'b0, 32'h0);
      @(negedge clk);
      checks++;
      if (grant_o !== 3'b000 || s_cyc_o !== 1'b0)
         begin failures++; $display("FAIL single_release grant=%b cyc=%b exp=000/0", grant_o, s_cyc_o); end
   endtask

   task automatic test_contention();
      int            order[$];
      int            exp_order[6];
      bit            rearm[NM];
      logic [NM-1:0] a, g;
      exp_order = '{0, 1, 2, 0, 1, 2};
      apply_reset();
      for (int k = 0; k < NM; k++) begin
         rearm[k] = 1'b0;
         drive(k, 1'b1, 32'h100 * 32'(k));
      end
      for (int c = 0; c < 60 && order.size() < 6; c++) begin
         @(negedge clk);
         a = m_ack_o;
         g = grant_o;
         for (int k = 0; k < NM; k++) begin
            if (rearm[k]) begin
               drive(k, 1'b1, 32'h100 * 32'(k));
               rearm[k] = 1'b0;
            end
         end
         if (a !== '0) begin
            checks++;
            if (a !== g)
               begin failures++; $display("FAIL rr_ack_route ack=%b grant=%b", a, g); end
            for (int k = 0; k < NM; k++) begin
               if (a[k]) begin
                  order.push_back(k);
                  drive(k, 1'b0, 32'h0);
                  rearm[k] = 1'b1;
               end
            end
         end
      end
      checks++;
      if (order.size() != 6)
         begin failures++; $display("FAIL rr_count got=%0d exp=6", order.size()); end
      for (int i = 0; i < 6 && i < order.size(); i++) begin
         checks++;
         if (order[i] != exp_order[i])
            begin failures++; $display("FAIL rr_order beat%0d got=%0d exp=%0d", i, order[i], exp_order[i]); end
      end
      m_cyc = '0;
      m_stb = '0;
   endtask

   task automatic test_held();
      int acks1;
      bit m0_ack_seen;
      bit grant_ok;
      bit got;
      acks1 = 0; m0_ack_seen = 1'b0; grant_ok = 1'b1;
      apply_reset();
      drive(1, 1'b1, 32'h2000_0010);
      @(negedge clk);
      drive(0, 1'b1, 32'h0000_0100);
      for (int i = 0; i < 40 && acks1 < 4; i++) begin
         @(negedge clk);
         if (m_ack_o[0]) m0_ack_seen = 1'b1;
         if (grant_o !== 3'b010) grant_ok = 1'b0;
         if (m_ack_o[1]) acks1++;
      end
      drive(1, 1'b0, 32'h0);
      checks++;
      if (acks1 != 4 || m0_ack_seen || !grant_ok)
         begin failures++; $display("FAIL held_owner acks1=%0d m0ack=%0d grant_kept=%0d exp=4/0/1", acks1, m0_ack_seen, grant_ok); end
      @(negedge clk);
      checks++;
      if (grant_o !== 3'b000)
         begin failures++; $display("FAIL held_gap got=%b exp=000", grant_o); end
      @(negedge clk);
      checks++;
      if (grant_o !== 3'b001 || s_adr_o !== 32'h0000_0100)
         begin failures++; $display("FAIL held_next grant=%b adr=%h exp=001/00000100", grant_o, s_adr_o); end
      wait_ack(0, 10, got);
      checks++;
      if (got !== 1'b1)
         begin failures++; $display("FAIL held_m0_ack got=%0d exp=1", got); end
   endtask

   task automatic test_timeout();
      int first_stb, err_cyc;
      bit got;
      first_stb = -1; err_cyc = -1;
      apply_reset();
      no_ack = 1'b1;
      drive(2, 1'b1, 32'h3000_0000);
      for (int i = 1; i <= 30 && err_cyc < 0; i++) begin
         @(negedge clk);
         if (s_stb_o === 1'b1 && first_stb < 0) first_stb = i;
         if (m_err_o !== '0 || timeout_o !== 1'b0) begin
            err_cyc = i;
            checks++;
            if (m_err_o !== 3'b100 || timeout_o !== 1'b1 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m_ack_o !== 3'b000)
               begin failures++; $display("FAIL to_abort err=%b to=%b cyc=%b stb=%b ack=%b exp=100/1/0/0/000", m_err_o, timeout_o, s_cyc_o, s_stb_o, m_ack_o); end
         end
         if (i == 1) drive(0, 1'b1, 32'h0000_0040);
      end
      no_ack = 1'b0;
      checks++;
      if (first_stb != 1 || err_cyc - first_stb != 16)
         begin failures++; $display("FAIL to_delay stb_at=%0d err_at=%0d exp=1/17", first_stb, err_cyc); end
      @(negedge clk);
      checks++;
      if (m_err_o !== 3'b000 || timeout_o !== 1'b0 || grant_o !== 3'b000)
         begin failures++; $display("FAIL to_pulse err=%b to=%b grant=%b exp=000/0/000", m_err_o, timeout_o, grant_o); end
      @(negedge clk);
      checks++;
      if (grant_o !== 3'b001)
         begin failures++; $display("FAIL to_next_grant got=%b exp=001", grant_o); end
      drive(2, 1'b0, 32'h0);
      wait_ack(0, 10, got);
      checks++;
      if (got !== 1'b1)
         begin failures++; $display("FAIL to_m0_ack got=%0d exp=1", got); end
   endtask

   task automatic test_reset_mid();
      bit got;
      apply_reset();
      no_ack = 1'b1;
      drive(0, 1'b1, 32'h0000_0050);
      @(negedge clk);
      drive(1, 1'b1, 32'h0000_0060);
      @(negedge clk);
      checks++;
      if (grant_o !== 3'b001 || s_cyc_o !== 1'b1)
         begin failures++; $display("FAIL rmid_pre grant=%b cyc=%b exp=001/1", grant_o, s_cyc_o); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 3'b000 || m_ack_o !== 3'b000 || m_err_o !== 3'b000 || timeout_o !== 1'b0)
         begin failures++; $display("FAIL rmid_async cyc=%b stb=%b grant=%b ack=%b err=%b to=%b exp=0", s_cyc_o, s_stb_o, grant_o, m_ack_o, m_err_o, timeout_o); end
      @(negedge clk);
      drive(0, 1'b0, 32'h0);
      no_ack = 1'b0;
      rst    = 1'b1;
      @(negedge clk);
      checks++;
      if (grant_o !== 3'b010)
         begin failures++; $display("FAIL rmid_regrant got=%b exp=010", grant_o); end
      wait_ack(1, 10, got);
      checks++;
      if (got !== 1'b1)
         begin failures++; $display("FAIL rmid_m1_ack got=%0d exp=1", got); end
   endtask

   task automatic test_back_to_back();
      bit got;
      apply_reset();
      lat = 2;
      drive(0, 1'b1, 32'h0000_0070);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk);
         #1;
         if (s_ack === 1'b1) begin
            got = 1'b1;
            drive(0, 1'b0, 32'h0);
         end
      end
      checks++;
      if (got !== 1'b1)
         begin failures++; $display("FAIL b2b_slave_ack got=%0d exp=1", got); end
      @(negedge clk);
      checks++;
      if (m_ack_o !== 3'b001 || s_cyc_o !== 1'b0)
         begin failures++; $display("FAIL b2b_ack_drop ack=%b cyc=%b exp=001/0", m_ack_o, s_cyc_o); end
      @(negedge clk);
      checks++;
      if (grant_o !== 3'b000 || m_ack_o !== 3'b000)
         begin failures++; $display("FAIL b2b_idle grant=%b ack=%b exp=000/000", grant_o, m_ack_o); end
      drive(0, 1'b1, 32'h0000_0074);
      drive(2, 1'b1, 32'h0000_0078);
      @(negedge clk);
      checks++;
      if (grant_o !== 3'b100 || s_adr_o !== 32'h0000_0078)
         begin failures++; $display("FAIL b2b_regrant grant=%b adr=%h exp=100/00000078", grant_o, s_adr_o); end
      wait_ack(2, 10, got);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (grant_o !== 3'b001)
         begin failures++; $display("FAIL b2b_wrap got=%b exp=001", grant_o); end
      wait_ack(0, 10, got);
      checks++;
      if (got !== 1'b1)
         begin failures++; $display("FAIL b2b_m0_ack got=%0d exp=1", got); end
   endtask

   initial begin
      m_cyc = '0; m_stb = '0; m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
      s_dat = '0;
      test_reset();
      test_single();
      test_contention();
      test_held();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout sim time exceeded");
      $fatal(1, "bench did not complete");
   end

endmodule
